// File: rtl/lane_pkg.sv
// Shared coordinate width and modular position helpers for the obstacle lane.
package lane_pkg;

  localparam int COORD_W = 12;

  // Starting position state of object k on a lane of length len.
  function automatic logic [COORD_W-1:0] init_pos(input int k, input int ix0,
                                                  input int spacing, input int len);
    return COORD_W'((ix0 + k * spacing) % len);
  endfunction

  function automatic logic [COORD_W-1:0] wrap_add(input logic [COORD_W-1:0] s,
                                                  input int step, input int len);
    logic [COORD_W:0] sum;
    sum = {1'b0, s} + (COORD_W+1)'(step);
    if (sum >= (COORD_W+1)'(len)) sum = sum - (COORD_W+1)'(len);
    return sum[COORD_W-1:0];
  endfunction

  function automatic logic [COORD_W-1:0] wrap_sub(input logic [COORD_W-1:0] s,
                                                  input int step, input int len);
    logic [COORD_W:0] dif;
    if ({1'b0, s} < (COORD_W+1)'(step))
      dif = {1'b0, s} + (COORD_W+1)'(len) - (COORD_W+1)'(step);
    else
      dif = {1'b0, s} - (COORD_W+1)'(step);
    return dif[COORD_W-1:0];
  endfunction

endpackage

// File: rtl/lane_obj.sv
// One obstacle: position register, modular step with wrap flag, and the
// combinational pixel-hit and player-overlap terms against the current position.
module lane_obj
  import lane_pkg::*;
#(
  parameter logic [COORD_W-1:0] INIT = '0,
  parameter int H_WIDTH  = 20,
  parameter int H_HEIGHT = 15,
  parameter int IY       = 240,
  parameter int STEP     = 1,
  parameter int L        = 680
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_step,
  input  logic               i_dir,
  input  logic [COORD_W-1:0] i_px,
  input  logic [COORD_W-1:0] i_py,
  input  logic [COORD_W-1:0] i_fx1,
  input  logic [COORD_W-1:0] i_fx2,
  input  logic [COORD_W-1:0] i_fy1,
  input  logic [COORD_W-1:0] i_fy2,
  output logic [COORD_W-1:0] o_pos_next,
  output logic               o_wrap,
  output logic               o_hit,
  output logic               o_collide
);

  localparam logic [COORD_W:0]   W2     = (COORD_W+1)'(2 * H_WIDTH);
  localparam logic [COORD_W-1:0] ROW_LO = COORD_W'(IY - H_HEIGHT);
  localparam logic [COORD_W-1:0] ROW_HI = COORD_W'(IY + H_HEIGHT);

  logic [COORD_W-1:0] pos;
  logic [COORD_W:0]   pos_w;
  logic               wrap_term;

  assign pos_w = {1'b0, pos};

  always_ff @(posedge i_clk) begin
    if (i_rst) pos <= INIT;
    else       pos <= o_pos_next;
  end

  always_comb begin
    wrap_term  = i_dir ? (pos_w + (COORD_W+1)'(STEP) >= (COORD_W+1)'(L))
                       : (pos_w < (COORD_W+1)'(STEP));
    o_pos_next = pos;
    if (i_step) o_pos_next = i_dir ? wrap_add(pos, STEP, L) : wrap_sub(pos, STEP, L);
    o_wrap     = i_step && wrap_term;
  end

  // Column span is [pos-2W, pos-1]; 13-bit sums keep px+2W from overflowing.
  always_comb begin
    o_hit     = ({1'b0, i_px} < pos_w) && ({1'b0, i_px} + W2 >= pos_w) &&
                (i_py >= ROW_LO) && (i_py <= ROW_HI);
    o_collide = ({1'b0, i_fx1} < pos_w) && ({1'b0, i_fx2} + W2 >= pos_w) &&
                (i_fy1 <= ROW_HI) && (i_fy2 >= ROW_LO);
  end

endmodule

// File: rtl/lane_scroller.sv
// Obstacle lane: strobe divider, N_OBJ wrapping obstacles, registered
// left-edge, hit, collide, step and wrap outputs.
module lane_scroller
  import lane_pkg::*;
#(
  parameter int N_OBJ    = 3,
  parameter int H_WIDTH  = 20,
  parameter int H_HEIGHT = 15,
  parameter int IY       = 240,
  parameter int IX0      = 40,
  parameter int SPACING  = 200,
  parameter int STEP     = 1,
  parameter int D_WIDTH  = 640,
  parameter int D_HEIGHT = 480
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_ani_stb,
  input  logic                       i_animate,
  input  logic                       i_dir,
  input  logic [3:0]                 i_period,
  input  logic [COORD_W-1:0]         i_px,
  input  logic [COORD_W-1:0]         i_py,
  input  logic [COORD_W-1:0]         i_fx1,
  input  logic [COORD_W-1:0]         i_fx2,
  input  logic [COORD_W-1:0]         i_fy1,
  input  logic [COORD_W-1:0]         i_fy2,
  output logic [COORD_W*N_OBJ-1:0]   o_left,
  output logic                       o_hit,
  output logic                       o_collide,
  output logic                       o_step,
  output logic                       o_wrap
);

  localparam int L = D_WIDTH + 2 * H_WIDTH;

  if (N_OBJ < 1 || N_OBJ > 8) begin : g_bad_nobj
    $error("lane_scroller: N_OBJ must be 1..8");
  end
  if (SPACING < 2 * H_WIDTH) begin : g_bad_spacing
    $error("lane_scroller: obstacles would overlap");
  end
  if (N_OBJ * SPACING > L) begin : g_bad_fill
    $error("lane_scroller: obstacles do not fit in the lane");
  end
  if (STEP >= L) begin : g_bad_step
    $error("lane_scroller: STEP must be below lane length");
  end
  if (IY - H_HEIGHT < 0 || IY + H_HEIGHT >= D_HEIGHT) begin : g_bad_row
    $error("lane_scroller: row does not fit on screen");
  end

  function automatic logic [COORD_W*N_OBJ-1:0] left_init();
    logic [COORD_W*N_OBJ-1:0] v;
    v = '0;
    for (int k = 0; k < N_OBJ; k++)
      v[COORD_W*k +: COORD_W] = init_pos(k, IX0, SPACING, L) - COORD_W'(2 * H_WIDTH);
    return v;
  endfunction

  logic [3:0]         cnt;
  logic               qual;
  logic               step;
  logic [COORD_W-1:0] pos_next [N_OBJ];
  logic [N_OBJ-1:0]   obj_wrap;
  logic [N_OBJ-1:0]   obj_hit;
  logic [N_OBJ-1:0]   obj_col;
  logic [COORD_W*N_OBJ-1:0] left_next;

  // A qualifying strobe with cnt at or past the period is a step; comparing
  // with >= lets a lowered period take effect at the next strobe.
  assign qual = i_animate && i_ani_stb;
  assign step = qual && (cnt >= i_period);

  always_ff @(posedge i_clk) begin
    if (i_rst)     cnt <= '0;
    else if (step) cnt <= '0;
    else if (qual) cnt <= cnt + 4'd1;
  end

  for (genvar k = 0; k < N_OBJ; k++) begin : g_obj
    lane_obj #(
      .INIT     (init_pos(k, IX0, SPACING, L)),
      .H_WIDTH  (H_WIDTH),
      .H_HEIGHT (H_HEIGHT),
      .IY       (IY),
      .STEP     (STEP),
      .L        (L)
    ) u_obj (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_step     (step),
      .i_dir      (i_dir),
      .i_px       (i_px),
      .i_py       (i_py),
      .i_fx1      (i_fx1),
      .i_fx2      (i_fx2),
      .i_fy1      (i_fy1),
      .i_fy2      (i_fy2),
      .o_pos_next (pos_next[k]),
      .o_wrap     (obj_wrap[k]),
      .o_hit      (obj_hit[k]),
      .o_collide  (obj_col[k])
    );
  end

  always_comb begin
    left_next = '0;
    for (int k = 0; k < N_OBJ; k++)
      left_next[COORD_W*k +: COORD_W] = pos_next[k] - COORD_W'(2 * H_WIDTH);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_left    <= left_init();
      o_hit     <= 1'b0;
      o_collide <= 1'b0;
      o_step    <= 1'b0;
      o_wrap    <= 1'b0;
    end else begin
      o_left    <= left_next;
      o_hit     <= |obj_hit;
      o_collide <= |obj_col;
      o_step    <= step;
      o_wrap    <= |obj_wrap;
    end
  end

endmodule

// File: tb/tb_lane_scroller.sv
// Bench for lane_scroller: table vectors, corner sequences and random
// stimulus against an arithmetic lane model.
module tb_lane_scroller;

  localparam int N   = 3;
  localparam int HW  = 20;
  localparam int HH  = 15;
  localparam int IY  = 240;
  localparam int L   = 680;
  localparam int STP = 1;

  logic        clk = 1'b0;
  logic        rst, stb, animate, dir;
  logic [3:0]  period;
  logic [11:0] px, py, fx1, fx2, fy1, fy2;
  logic [35:0] o_left;
  logic        o_hit, o_collide, o_step, o_wrap;

  int checks = 0;
  int errors = 0;

  int s_m [N];
  int cnt_m;

  always #5 clk = ~clk;

  lane_scroller dut (
    .i_clk(clk), .i_rst(rst), .i_ani_stb(stb), .i_animate(animate), .i_dir(dir),
    .i_period(period), .i_px(px), .i_py(py), .i_fx1(fx1), .i_fx2(fx2),
    .i_fy1(fy1), .i_fy2(fy2), .o_left(o_left), .o_hit(o_hit),
    .o_collide(o_collide), .o_step(o_step), .o_wrap(o_wrap)
  );

  typedef struct {
    int px, py, fx1, fx2, fy1, fy2;
    bit exp_hit, exp_col;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) s_m[k] = (40 + k * 200) % L;
    cnt_m = 0;
  endtask

  // Expectations come from the pre-edge lane state; the model then advances.
  task automatic tick();
    bit e_hit, e_col, e_step, e_wrap;
    logic [35:0] e_left;
    e_hit = 0; e_col = 0; e_wrap = 0;
    for (int k = 0; k < N; k++) begin
      int s;
      s = s_m[k];
      if (int'(px) < s && int'(px) + 2*HW >= s && int'(py) >= IY-HH && int'(py) <= IY+HH)
        e_hit = 1;
      if (int'(fx1) < s && int'(fx2) + 2*HW >= s && int'(fy1) <= IY+HH && int'(fy2) >= IY-HH)
        e_col = 1;
    end
    e_step = animate && stb && (cnt_m >= int'(period));
    if (rst) begin
      model_reset();
      e_hit = 0; e_col = 0; e_step = 0;
    end else begin
      if (animate && stb) cnt_m = e_step ? 0 : cnt_m + 1;
      if (e_step)
        for (int k = 0; k < N; k++) begin
          if (dir) begin
            if (s_m[k] + STP >= L) e_wrap = 1;
            s_m[k] = (s_m[k] + STP) % L;
          end else begin
            if (s_m[k] < STP) e_wrap = 1;
            s_m[k] = (s_m[k] - STP + L) % L;
          end
        end
    end
    e_left = '0;
    for (int k = 0; k < N; k++) e_left[12*k +: 12] = 12'(s_m[k] - 2*HW);
    @(posedge clk);
    #1;
    chk("o_left", 64'(o_left), 64'(e_left));
    chk("o_hit", 64'(o_hit), 64'(e_hit));
    chk("o_collide", 64'(o_collide), 64'(e_col));
    chk("o_step", 64'(o_step), 64'(e_step));
    chk("o_wrap", 64'(o_wrap), 64'(e_wrap));
  endtask

  task automatic do_reset();
    rst = 1; stb = 0; animate = 0;
    tick();
    rst = 0;
  endtask

  initial begin
    vec_t vecs [6];
    int strobe_mask, nsteps;
    logic [35:0] frozen;

    rst = 1; stb = 0; animate = 0; dir = 1; period = 0;
    px = 0; py = 0; fx1 = 0; fx2 = 0; fy1 = 0; fy2 = 0;
    model_reset();
    @(negedge clk);
    do_reset();
    chk("reset_left", 64'(o_left), 64'({12'd400, 12'd200, 12'd0}));
    chk("reset_flags", 64'({o_hit, o_collide, o_step, o_wrap}), 64'(0));

    vecs[0] = '{0,   240, 30,  50,  230, 250, 1'b1, 1'b1};
    vecs[1] = '{40,  240, 30,  50,  300, 320, 1'b0, 1'b0};
    vecs[2] = '{10,  256, 0,   0,   230, 250, 1'b0, 1'b1};
    vecs[3] = '{239, 225, 600, 639, 255, 300, 1'b1, 1'b0};
    vecs[4] = '{199, 240, 440, 500, 0,   225, 1'b0, 1'b0};
    vecs[5] = '{439, 255, 439, 439, 0,   225, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) begin
      px = 12'(vecs[i].px); py = 12'(vecs[i].py);
      fx1 = 12'(vecs[i].fx1); fx2 = 12'(vecs[i].fx2);
      fy1 = 12'(vecs[i].fy1); fy2 = 12'(vecs[i].fy2);
      tick();
      chk($sformatf("vec%0d_hit", i), 64'(o_hit), 64'(vecs[i].exp_hit));
      chk($sformatf("vec%0d_col", i), 64'(o_collide), 64'(vecs[i].exp_col));
    end

    // First step to the right, then run obstacle 2 up to the wrap point.
    period = 0; dir = 1; animate = 1; stb = 1;
    tick();
    chk("step1_left", 64'(o_left), 64'({12'd401, 12'd201, 12'd1}));
    chk("step1_pulse", 64'({o_step, o_wrap}), 64'(2'b10));
    stb = 0;
    tick();
    chk("step1_once", 64'(o_step), 64'(0));
    stb = 1;
    for (int i = 0; i < 238; i++) tick();
    chk("right_679", 64'(o_left[35:24]), 64'(12'd639));
    tick();
    chk("right_wrap", 64'(o_wrap), 64'(1));
    chk("right_wrap_left", 64'(o_left[35:24]), 64'(12'hfd8));
    stb = 0;
    tick();
    chk("right_wrap_once", 64'(o_wrap), 64'(0));

    // Left wrap of obstacle 0.
    do_reset();
    dir = 0; animate = 1; stb = 1;
    for (int i = 0; i < 40; i++) tick();
    chk("left_zero", 64'({o_wrap, o_left[11:0]}), 64'({1'b0, 12'hfd8}));
    tick();
    chk("left_wrap", 64'({o_wrap, o_left[11:0]}), 64'({1'b1, 12'd639}));

    // Divider: period 2 steps on strobes 3, 6, 9.
    do_reset();
    period = 2; dir = 1; animate = 1;
    strobe_mask = 0; nsteps = 0;
    for (int i = 1; i <= 9; i++) begin
      stb = 1; tick();
      if (o_step) begin strobe_mask |= (1 << i); nsteps++; end
      stb = 0; tick(); tick();
    end
    chk("div_count", 64'(nsteps), 64'(3));
    chk("div_mask", 64'(strobe_mask), 64'((1 << 3) | (1 << 6) | (1 << 9)));

    // Freeze mid-count: one strobe, then strobes while paused change nothing.
    stb = 1; tick();
    frozen = o_left;
    animate = 0;
    for (int i = 0; i < 5; i++) tick();
    chk("freeze_left", 64'(o_left), 64'(frozen));
    animate = 1;
    tick();
    chk("freeze_cnt_kept", 64'(o_step), 64'(0));
    tick();
    chk("freeze_then_step", 64'(o_step), 64'(1));

    // Reset on the same cycle as a step strobe.
    do_reset();
    period = 2; animate = 1; stb = 1;
    tick(); tick();
    rst = 1;
    tick();
    rst = 0;
    chk("rst_step_pulse", 64'(o_step), 64'(0));
    chk("rst_step_left", 64'(o_left), 64'({12'd400, 12'd200, 12'd0}));
    period = 1;
    tick();
    chk("rst_cnt_zero", 64'(o_step), 64'(0));
    tick();
    chk("rst_cnt_step", 64'(o_step), 64'(1));

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst     = ($urandom_range(0, 199) == 0);
      stb     = ($urandom_range(0, 2) == 0);
      animate = ($urandom_range(0, 7) != 0);
      dir     = ($urandom_range(0, 9) < 6);
      period  = 4'($urandom_range(0, 3));
      px  = 12'($urandom_range(0, 700));
      py  = 12'($urandom_range(200, 280));
      fx1 = 12'($urandom_range(0, 660));
      fx2 = fx1 + 12'($urandom_range(0, 40));
      fy1 = 12'($urandom_range(180, 270));
      fy2 = fy1 + 12'($urandom_range(0, 30));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lane_scroller.md
# lane_scroller

Parametrised obstacle lane for the Finalproj1 VGA game. It moves N_OBJ equally spaced obstacles along one horizontal row with wrap-around, at a runtime-selectable speed and direction. It answers a per-pixel "obstacle here" query for the draw path and a bounding-box overlap query for player collision. Sits between the frame-strobe generator and the pixel mux / game-state FSM; one instance per lane.

## Interface
- N_OBJ, 3: obstacles in the lane (1–8)
- H_WIDTH, 20: half obstacle width, px
- H_HEIGHT, 15: half obstacle height, px
- IY, 240: row centre y
- IX0, 40: initial position state of obstacle 0
- SPACING, 200: position-state distance between consecutive obstacles
- STEP, 1: pixels moved per step
- D_WIDTH, 640: display width
- D_HEIGHT, 480: display height
- i_clk  in  1  base clock; single clock domain
- i_rst  in  1  reset: synchronous, active-high; returns the lane to its initial state
- i_ani_stb  in  1  one-cycle animation strobe, once per frame
- i_animate  in  1  lane moves only while high
- i_dir  in  1  1 = right, 0 = left; sampled on step cycles
- i_period  in  4  step once every i_period+1 qualifying strobes
- i_px, i_py  in  12 each  pixel query coordinate
- i_fx1, i_fx2, i_fy1, i_fy2  in  12 each  player box, inclusive edges, x1≤x2, y1≤y2
- o_left  out  12·N_OBJ  packed left edge of each obstacle (object k at bits [12k+11:12k])
- o_hit  out  1  query pixel lies inside some obstacle
- o_collide  out  1  player box overlaps some obstacle
- o_step  out  1  one-cycle pulse on every lane step
- o_wrap  out  1  one-cycle pulse when any obstacle wraps

## Operation
- Lane length: L = D_WIDTH + 2·H_WIDTH. Each object holds position state s ∈ [0, L−1].
- Object covers screen columns [s−2·H_WIDTH, s−1] and rows [IY−H_HEIGHT, IY+H_HEIGHT].
- o_left = s − 2·H_WIDTH, taken modulo 2^12. It wraps high while the object is partly off the left edge; consumers use o_hit.
- Initial state: s_k = (IX0 + k·SPACING) mod L, computed at elaboration.
- Elaboration checks: SPACING ≥ 2·H_WIDTH, N_OBJ·SPACING ≤ L, STEP < L, and IY ± H_HEIGHT must lie within D_HEIGHT.
- Divider: a 4-bit counter cnt advances on cycles where i_animate && i_ani_stb.
  - When cnt ≥ i_period, that cycle is a step cycle and cnt returns to 0. Otherwise cnt increments.
  - Lowering i_period therefore takes effect at the next strobe.
- On a step cycle, every object moves by STEP in direction i_dir:
  - Right: s' = s+STEP, minus L if s+STEP ≥ L.
  - Left: s' = s−STEP, plus L if s < STEP.
  - If any object took the wrap term, o_wrap is asserted.
- When i_animate is low, positions and cnt are held.
- Reset has priority over everything. i_rst together with a step cycle yields the reset state.
- Hit test: o_hit = OR over k of (i_px < s_k && i_px + 2·H_WIDTH ≥ s_k && i_py in row range).
  - The comparison uses 13-bit arithmetic to avoid overflow.
- Collide test: o_collide = OR over k of (i_fx1 < s_k && i_fx2 + 2·H_WIDTH ≥ s_k && i_fy1 ≤ IY+H_HEIGHT && i_fy2 ≥ IY−H_HEIGHT).

## Timing
- All outputs are registered.
- o_hit and o_collide: one cycle latency from i_px/i_py/i_f*, evaluated against the s values of that same cycle.
- Positions update on the clock edge ending a step cycle. o_left reflects the new s in the next cycle. o_step and o_wrap are high during that same next cycle, for exactly one cycle.
- Reset values: s_k initial, cnt 0, o_hit 0, o_collide 0, o_step 0, o_wrap 0, o_left = initial s_k − 2·H_WIDTH.
- A direction change takes effect at the next step. There is no turnaround cycle.
- No handshake. Inputs are assumed stable and synchronous to i_clk.

## Structure
- Package lane_pkg:
  - COORD_W = 12
  - function init_pos(k) returning (IX0 + k·SPACING) mod L
  - function wrap_add / wrap_sub for the modular step
- Sub-module lane_obj: one position register, the step/wrap logic, and combinational hit/collide terms. Instantiated N_OBJ times by generate.
- Top level holds the divider, the OR-reductions, and the output registers.

## Test plan
All scenarios use default parameters: L = 680, s = 40/240/440.
- Reset → o_left = 0/200/400; o_hit, o_collide, o_step, o_wrap all 0.
- i_period = 0, i_dir = 1, i_animate = 1, one strobe → s = 41/241/441, o_left = 1/201/401, o_step high for 1 cycle, o_wrap 0.
- Right wrap: drive until s_2 = 679, then one more step → s_2 = 0 with o_wrap pulse. Left: i_dir = 0 at s_0 = 0 → s_0 = 679 with o_wrap pulse.
- i_period = 2, 9 strobes → exactly 3 o_step pulses, on strobes 3, 6 and 9. Drop i_animate mid-run → positions and cnt frozen.
- After reset:
  - px = 0, py = 240 → o_hit = 1 next cycle.
  - px = 40 → o_hit = 0.
  - py = 256 → o_hit = 0.
  - Box x [30,50], y [230,250] → o_collide = 1.
  - Box y [300,320] → o_collide = 0.
- i_rst asserted on the same cycle as a step strobe, mid-count → initial positions restored, cnt 0, no o_step pulse.
